coop_comm_rx_parser: RTL and testbench
======================================

COOP_COMM_RX_PARSER -- requirements
Module: coop_comm_rx_parser

Interface
REQ-001 SHALL have parameter FCLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_MS, default 200, meaning the link-loss window in ms; TO_CYCLES = (FCLK_HZ/1000)*TIMEOUT_MS.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on posedge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port rx_empty, input, 1, UART RX FIFO empty flag.
REQ-006 SHALL have port r_data, input, 8, UART RX FIFO head byte, valid while rx_empty=0.
REQ-007 SHALL have port rd_uart, output, 1, one-cycle FIFO pop strobe.
REQ-008 SHALL have port remote_xpos, output, 12, last accepted remote player x-position.
REQ-009 SHALL have port xpos_valid, output, 1, one-cycle pulse on each accepted frame.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on each rejected frame.
REQ-011 SHALL have port link_alive, output, 1, high while frames arrive within the timeout window.
REQ-012 SHALL have port err_cnt, output, 8, saturating count of rejected frames.

Function
REQ-013 SHALL parse the frame format 'P' ':' D3 D2 D1 D0 CR(0x0D) LF(0x0A), Dn ASCII '0'..'9', decimal MSD first.
REQ-014 SHALL use byte-fetch FSM states S_FETCH and S_PARSE; all outputs registered.
REQ-015 In S_FETCH with rx_empty=1: SHALL stay in S_FETCH, rd_uart=0.
REQ-016 In S_FETCH with rx_empty=0: SHALL latch r_data into a byte register, go to S_PARSE, with rd_uart=1 during the S_PARSE cycle.
REQ-017 S_PARSE SHALL always return to S_FETCH next cycle; max throughput one byte per 2 cycles; rd_uart never high on two consecutive cycles.
REQ-018 SHALL track frame position idx 0..7 (3 bits); idx=0 at reset and after every frame end or error.
REQ-019 idx0 expects 'P', idx1 ':', idx2..5 digit, idx6 CR, idx7 LF; a matching byte SHALL increment idx.
REQ-020 On idx2 SHALL load acc = digit; on idx3..5 SHALL set acc = acc*10 + digit; acc is 14 bits (max 9999).
REQ-021 Mismatched byte at idx0: SHALL silently discard it, no frame_err (inter-frame garbage).
REQ-022 Mismatched byte at idx1..7: SHALL pulse frame_err, increment err_cnt, and set idx=1 if the byte is 'P', else idx=0.
REQ-023 LF at idx7 with acc <= 4095: SHALL update remote_xpos = acc[11:0] and pulse xpos_valid the cycle after S_PARSE.
REQ-024 LF at idx7 with acc > 4095: SHALL pulse frame_err, increment err_cnt, and leave remote_xpos unchanged.
REQ-025 err_cnt SHALL saturate at 255 and not wrap.
REQ-026 xpos_valid and frame_err SHALL never be high in the same cycle.
REQ-027 SHALL reload a timeout counter to TO_CYCLES-1 and set link_alive=1 on each xpos_valid.
REQ-028 Timeout counter SHALL otherwise decrement to 0; on reaching 0, link_alive SHALL go 0.
REQ-029 A valid frame completing in the same cycle the timer reaches 0 SHALL win: link_alive stays 1, timer reloads.
REQ-030 SHALL ignore r_data when rx_empty=1; no pop is issued on an empty FIFO.

Reset
REQ-031 On rst SHALL force FSM=S_FETCH, idx=0, acc=0, rd_uart=0, remote_xpos=0, xpos_valid=0, frame_err=0, link_alive=0, err_cnt=0, timer=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; the next frame parses from idx0 after rst deasserts.

Verification
REQ-033 Feed "P:0123\r\n" -> exactly 8 rd_uart pulses, remote_xpos=123, one xpos_valid pulse, link_alive=1, err_cnt=0.
REQ-034 Feed "P:12a4\r\n" then "P:0640\r\n" -> one frame_err at 'a', err_cnt=1, remote_xpos=640 after the second frame.
REQ-035 Feed "P:5000\r\n" after a 123 frame -> frame_err pulse, remote_xpos stays 123, no xpos_valid.
REQ-036 Feed "xyP:0001\r\n" -> no frame_err, remote_xpos=1; feed "P:0P:0002\r\n" -> one frame_err, then remote_xpos=2.
REQ-037 With TIMEOUT_MS scaled to TO_CYCLES=100, send one valid frame then idle -> link_alive falls exactly 100 cycles after xpos_valid.
REQ-038 Assert rst after "P:01" -> all outputs at reset values; then "P:4095\r\n" -> remote_xpos=4095; 300 bad frames -> err_cnt=255.

Source files
------------

// File: rtl/coop_comm_rx_parser.sv
// Receive-side parser for the co-op link: pops bytes from the UART RX FIFO,
// decodes "P:DDDD\r\n" position frames and tracks link liveness and errors.
module coop_comm_rx_parser #(
    parameter int FCLK_HZ    = 100_000_000,
    parameter int TIMEOUT_MS = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    output logic [11:0] remote_xpos,
    output logic        xpos_valid,
    output logic        frame_err,
    output logic        link_alive,
    output logic [7:0]  err_cnt
);

    localparam int TO_CYCLES = (FCLK_HZ / 1000) * TIMEOUT_MS;
    localparam int TW        = $clog2(TO_CYCLES + 1);

    localparam logic [7:0] CH_P     = 8'h50;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [2:0] IDX_LAST = 3'd7;

    typedef enum logic {
        S_FETCH,
        S_PARSE
    } state_t;

    state_t        state_reg,      state_next;
    logic [7:0]    byte_reg,       byte_next;
    logic          rd_uart_reg,    rd_uart_next;
    logic [2:0]    idx_reg,        idx_next;
    logic [13:0]   acc_reg,        acc_next;
    logic [11:0]   xpos_reg,       xpos_next;
    logic          xpos_valid_reg, xpos_valid_next;
    logic          frame_err_reg,  frame_err_next;
    logic [7:0]    err_cnt_reg,    err_cnt_next;
    logic [TW-1:0] timer_reg,      timer_next;
    logic          alive_reg,      alive_next;

    logic          is_digit;
    logic [3:0]    digit;
    logic [7:0]    pos_match;
    logic          byte_match;

    // Fixed literal expected at each non-digit frame position.
    function automatic logic [7:0] pos_char(input int p);
        case (p)
            0:       pos_char = CH_P;
            1:       pos_char = CH_COLON;
            6:       pos_char = CH_CR;
            default: pos_char = CH_LF;
        endcase
    endfunction

    assign is_digit = (byte_reg >= CH_0) && (byte_reg <= CH_9);
    assign digit    = byte_reg[3:0];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pos
            if (gi >= 2 && gi <= 5) begin : g_digit
                assign pos_match[gi] = is_digit;
            end else begin : g_lit
                assign pos_match[gi] = (byte_reg == pos_char(gi));
            end
        end
    endgenerate

    assign byte_match = pos_match[idx_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_FETCH;
            byte_reg       <= 8'd0;
            rd_uart_reg    <= 1'b0;
            idx_reg        <= 3'd0;
            acc_reg        <= 14'd0;
            xpos_reg       <= 12'd0;
            xpos_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_cnt_reg    <= 8'd0;
            timer_reg      <= '0;
            alive_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_reg       <= byte_next;
            rd_uart_reg    <= rd_uart_next;
            idx_reg        <= idx_next;
            acc_reg        <= acc_next;
            xpos_reg       <= xpos_next;
            xpos_valid_reg <= xpos_valid_next;
            frame_err_reg  <= frame_err_next;
            err_cnt_reg    <= err_cnt_next;
            timer_reg      <= timer_next;
            alive_reg      <= alive_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        byte_next       = byte_reg;
        rd_uart_next    = 1'b0;
        idx_next        = idx_reg;
        acc_next        = acc_reg;
        xpos_next       = xpos_reg;
        xpos_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        case (state_reg)
            S_FETCH: begin
                if (!rx_empty) begin
                    byte_next    = r_data;
                    rd_uart_next = 1'b1;
                    state_next   = S_PARSE;
                end
            end
            S_PARSE: begin
                state_next = S_FETCH;
                if (byte_match) begin
                    if (idx_reg == IDX_LAST) begin
                        idx_next = 3'd0;
                        if (acc_reg <= 14'd4095) begin
                            xpos_next       = acc_reg[11:0];
                            xpos_valid_next = 1'b1;
                        end else begin
                            frame_err_next = 1'b1;
                        end
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        if (idx_reg == 3'd2) begin
                            acc_next = {10'd0, digit};
                        end else if (idx_reg >= 3'd3 && idx_reg <= 3'd5) begin
                            acc_next = acc_reg * 14'd10 + {10'd0, digit};
                        end
                    end
                end else if (idx_reg != 3'd0) begin
                    // A stray 'P' is taken as the start of a fresh frame.
                    frame_err_next = 1'b1;
                    idx_next       = (byte_reg == CH_P) ? 3'd1 : 3'd0;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (frame_err_next && err_cnt_reg != 8'hFF) begin
            err_cnt_next = err_cnt_reg + 8'd1;
        end
    end

    // A frame accepted on the same edge the timer expires keeps the link up.
    always_comb begin
        timer_next = timer_reg;
        alive_next = alive_reg;
        if (xpos_valid_next) begin
            timer_next = TW'(TO_CYCLES - 1);
            alive_next = 1'b1;
        end else if (timer_reg != '0) begin
            timer_next = timer_reg - TW'(1);
        end else begin
            alive_next = 1'b0;
        end
    end

    assign rd_uart     = rd_uart_reg;
    assign remote_xpos = xpos_reg;
    assign xpos_valid  = xpos_valid_reg;
    assign frame_err   = frame_err_reg;
    assign link_alive  = alive_reg;
    assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_coop_comm_rx_parser.sv
// Scoreboard bench for coop_comm_rx_parser: a FIFO model feeds frames, expected
// accept/reject events are queued at issue time and checked by a monitor.
module tb_coop_comm_rx_parser;

    localparam int FCLK_HZ    = 100_000;
    localparam int TIMEOUT_MS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        rd_uart;
    logic [11:0] remote_xpos;
    logic        xpos_valid;
    logic        frame_err;
    logic        link_alive;
    logic [7:0]  err_cnt;

    coop_comm_rx_parser #(
        .FCLK_HZ    (FCLK_HZ),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_empty    (rx_empty),
        .r_data      (r_data),
        .rd_uart     (rd_uart),
        .remote_xpos (remote_xpos),
        .xpos_valid  (xpos_valid),
        .frame_err   (frame_err),
        .link_alive  (link_alive),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int xpos;
        int ecnt;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fifo_q[$];
    int         checks = 0;
    int         errors = 0;
    int         rd_cnt = 0;
    logic       rd_prev = 1'b0;
    int         exp_err = 0;
    int         exp_xpos = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: pop on the negedge inside the rd_uart cycle, then republish the head.
    always @(negedge clk) begin
        if (rd_uart === 1'b1) begin
            rd_cnt++;
            chk("rd_uart_back_to_back", int'(rd_prev), 0);
            chk("pop_on_nonempty", int'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        rd_prev = rd_uart;
        #1;
        rx_empty = (fifo_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo_q[0];
    end

    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst && (xpos_valid === 1'b1 || frame_err === 1'b1)) begin
            chk("valid_err_exclusive", int'(xpos_valid && frame_err), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got valid=%0d err=%0d xpos=%0d, expected no event",
                         xpos_valid, frame_err, remote_xpos);
            end else begin
                e = exp_q.pop_front();
                $display("[%0t] %s xpos=%0d err_cnt=%0d", $time,
                         frame_err ? "reject" : "accept", remote_xpos, err_cnt);
                chk("event_kind_err", int'(frame_err), int'(e.is_err));
                chk("event_xpos", int'(remote_xpos), e.xpos);
                chk("event_err_cnt", int'(err_cnt), e.ecnt);
            end
        end
    end

    task automatic push_str(input string s, input bit crlf);
        @(negedge clk);
        for (int i = 0; i < s.len(); i++) fifo_q.push_back(s[i]);
        if (crlf) begin
            fifo_q.push_back(8'h0D);
            fifo_q.push_back(8'h0A);
        end
    endtask

    task automatic expect_valid(input int x);
        ev_t e;
        exp_xpos = x;
        e = '{1'b0, x, exp_err};
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        ev_t e;
        if (exp_err < 255) exp_err++;
        e = '{1'b1, exp_xpos, exp_err};
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_q.size() != 0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("fifo_drained", fifo_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_uart"},     int'(rd_uart), 0);
        chk({tag, "_remote_xpos"}, int'(remote_xpos), 0);
        chk({tag, "_xpos_valid"},  int'(xpos_valid), 0);
        chk({tag, "_frame_err"},   int'(frame_err), 0);
        chk({tag, "_link_alive"},  int'(link_alive), 0);
        chk({tag, "_err_cnt"},     int'(err_cnt), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame
        rd_cnt = 0;
        expect_valid(123);
        push_str("P:0123", 1'b1);
        drain();
        chk("f123_rd_pulses", rd_cnt, 8);
        chk("f123_xpos", int'(remote_xpos), 123);
        chk("f123_link_alive", int'(link_alive), 1);
        chk("f123_err_cnt", int'(err_cnt), 0);

        // Out-of-range value
        expect_err();
        push_str("P:5000", 1'b1);
        drain();
        chk("f5000_xpos_kept", int'(remote_xpos), 123);
        chk("f5000_err_cnt", int'(err_cnt), 1);

        // Bad digit, trailing bytes discarded, then a good frame
        expect_err();
        push_str("P:12a4", 1'b1);
        drain();
        chk("bad_digit_err_cnt", int'(err_cnt), 2);
        expect_valid(640);
        push_str("P:0640", 1'b1);
        drain();
        chk("f640_xpos", int'(remote_xpos), 640);

        // Leading garbage and a restart on stray 'P'
        expect_valid(1);
        push_str("xyP:0001", 1'b1);
        drain();
        chk("garbage_err_cnt", int'(err_cnt), 2);
        chk("f0001_xpos", int'(remote_xpos), 1);
        expect_err();
        expect_valid(2);
        push_str("P:0P:0002", 1'b1);
        drain();
        chk("restart_err_cnt", int'(err_cnt), 3);
        chk("f0002_xpos", int'(remote_xpos), 2);

        // Link timeout: 100 cycles at these parameters
        repeat (120) @(negedge clk);
        chk("idle_link_dead", int'(link_alive), 0);
        expect_valid(7);
        push_str("P:0007", 1'b1);
        n = 0;
        while (xpos_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_frame_seen", int'(xpos_valid), 1);
        chk("timeout_alive_at_valid", int'(link_alive), 1);
        n = 0;
        while (link_alive === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("link_alive_fall_cycles", n, 100);

        // Reset in the middle of a frame
        push_str("P:01", 1'b0);
        drain();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_err  = 0;
        exp_xpos = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_valid(4095);
        push_str("P:4095", 1'b1);
        drain();
        chk("f4095_xpos", int'(remote_xpos), 4095);

        // Error counter saturation
        for (int i = 0; i < 300; i++) expect_err();
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            fifo_q.push_back(8'h50);
            fifo_q.push_back(8'h3A);
            fifo_q.push_back(8'h58);
        end
        drain();
        chk("err_cnt_saturated", int'(err_cnt), 255);
        chk("sat_xpos_kept", int'(remote_xpos), 4095);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
